// File: rtl/decode_pkg.sv
// Shared decode definitions: RISC-V base opcodes, immediate-format
// classification and source-operand usage helpers.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Immediate format implied by the major opcode.
  function automatic imm_type_e get_imm_type(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: t = IMM_I;
      OP_STORE:                            t = IMM_S;
      OP_BRANCH:                           t = IMM_B;
      OP_LUI, OP_AUIPC:                    t = IMM_U;
      OP_JAL:                              t = IMM_J;
      default:                             t = IMM_NONE;
    endcase
    return t;
  endfunction

  // rs1 is meaningful for everything except U- and J-format instructions.
  function automatic logic src1_used(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  // rs2 is meaningful only for register-register, store and branch.
  function automatic logic src2_used(input logic [6:0] opcode);
    return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen_mp.sv
// Combinational immediate generator: extracts the I/S/B/U/J immediate
// selected by the opcode and sign-extends it from instr[31] to XLEN.
module imm_gen_mp
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  // Assemble the 32-bit immediate for the decoded format.
  always_comb begin
    w_imm32 = '0;
    case (get_imm_type(i_instr[6:0]))
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'h000};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage_mp.sv
// Decode stage: register file with multi-port writeback and write-through
// bypass, immediate extension, optional issue scoreboard / RAW interlock,
// and a valid/ready output register.
// Optional feature macro: DECODE_SCOREBOARD_EN (scoreboard + hazard logic).
module decode_stage_mp
  import decode_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NWB  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_instr,
  input  logic                flush,
  input  logic [NWB-1:0]      wb_we,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [31:0]         out_instr,
  output logic [AW-1:0]       out_rs1,
  output logic [AW-1:0]       out_rs2,
  output logic [AW-1:0]       out_rd,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_rd_we
);

  logic [XLEN-1:0] r_regs [NREG];

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [31:0]     r_out_instr;
  logic [AW-1:0]   r_out_rs1;
  logic [AW-1:0]   r_out_rs2;
  logic [AW-1:0]   r_out_rd;
  logic [XLEN-1:0] r_out_rs1_data;
  logic [XLEN-1:0] r_out_rs2_data;
  logic [XLEN-1:0] r_out_imm;
  logic            r_out_rd_we;

  logic [6:0]      w_opcode;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic            w_rd_we;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_rs1    = AW'(in_instr[19:15]);
  assign w_rs2    = AW'(in_instr[24:20]);
  assign w_rd     = AW'(in_instr[11:7]);
  assign w_rd_we  = (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH) && (w_rd != '0);

  imm_gen_mp #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr (in_instr),
    .o_imm   (w_imm)
  );

  // Register file write: ascending port order so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NWB; i++) begin
        if (wb_we[i] && (wb_addr[i*AW +: AW] != '0) &&
            (int'(wb_addr[i*AW +: AW]) < NREG)) begin
          r_regs[wb_addr[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Operand read with same-cycle writeback bypass; later ports override earlier.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if ((w_rs1 != '0) && (int'(w_rs1) < NREG)) w_rs1_data = r_regs[w_rs1];
    if ((w_rs2 != '0) && (int'(w_rs2) < NREG)) w_rs2_data = r_regs[w_rs2];
    for (int unsigned i = 0; i < NWB; i++) begin
      if (wb_we[i] && (w_rs1 != '0) && (wb_addr[i*AW +: AW] == w_rs1)) begin
        w_rs1_data = wb_data[i*XLEN +: XLEN];
      end
      if (wb_we[i] && (w_rs2 != '0) && (wb_addr[i*AW +: AW] == w_rs2)) begin
        w_rs2_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

`ifdef DECODE_SCOREBOARD_EN
  localparam int NSB = 1 << AW;

  logic [NSB-1:0] r_busy;
  logic [NSB-1:0] w_wb_hit;
  logic [NSB-1:0] w_busy_nxt;
  logic           w_issue;
  logic           w_src1_pend;
  logic           w_src2_pend;

  assign w_issue = r_out_valid && out_ready && !flush;

  // Mask of registers receiving a writeback this cycle.
  always_comb begin
    w_wb_hit = '0;
    for (int unsigned i = 0; i < NWB; i++) begin
      if (wb_we[i]) w_wb_hit[wb_addr[i*AW +: AW]] = 1'b1;
    end
  end

  // Busy update: clears from older writebacks first, then the issuing set wins.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_hit;
    if (w_issue && r_out_rd_we) w_busy_nxt[r_out_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Source is pending if its writer is in flight without a writeback this
  // cycle, or if its writer still sits in the output register.
  always_comb begin
    w_src1_pend = (w_rs1 != '0) &&
                  ((r_busy[w_rs1] && !w_wb_hit[w_rs1]) ||
                   (r_out_valid && r_out_rd_we && (r_out_rd == w_rs1)));
    w_src2_pend = (w_rs2 != '0) &&
                  ((r_busy[w_rs2] && !w_wb_hit[w_rs2]) ||
                   (r_out_valid && r_out_rd_we && (r_out_rd == w_rs2)));
    w_hazard = (src1_used(w_opcode) && w_src1_pend) ||
               (src2_used(w_opcode) && w_src2_pend);
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end
`else
  assign w_hazard = 1'b0;
`endif

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Output register: flush kills, accept loads, consumption without refill empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_instr    <= '0;
      r_out_rs1      <= '0;
      r_out_rs2      <= '0;
      r_out_rd       <= '0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_imm      <= '0;
      r_out_rd_we    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= in_pc;
      r_out_instr    <= in_instr;
      r_out_rs1      <= w_rs1;
      r_out_rs2      <= w_rs2;
      r_out_rd       <= w_rd;
      r_out_rs1_data <= w_rs1_data;
      r_out_rs2_data <= w_rs2_data;
      r_out_imm      <= w_imm;
      r_out_rd_we    <= w_rd_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_instr    = r_out_instr;
  assign out_rs1      = r_out_rs1;
  assign out_rs2      = r_out_rs2;
  assign out_rd       = r_out_rd;
  assign out_rs1_data = r_out_rs1_data;
  assign out_rs2_data = r_out_rs2_data;
  assign out_imm      = r_out_imm;
  assign out_rd_we    = r_out_rd_we;

endmodule

// File: tb/tb_decode_stage_mp.sv
// Scoreboard bench for decode_stage_mp: a driver computes expected bundles
// from an array-based architectural model and queues them; a monitor pops and
// compares whenever the DUT presents a bundle. Honours DECODE_SCOREBOARD_EN.
module tb_decode_stage_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NWB  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [31:0]         in_instr;
  logic                flush;
  logic [NWB-1:0]      wb_we;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*XLEN-1:0] wb_data;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [31:0]         out_instr;
  logic [AW-1:0]       out_rs1;
  logic [AW-1:0]       out_rs2;
  logic [AW-1:0]       out_rd;
  logic [XLEN-1:0]     out_rs1_data;
  logic [XLEN-1:0]     out_rs2_data;
  logic [XLEN-1:0]     out_imm;
  logic                out_rd_we;

  decode_stage_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NWB  (NWB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_rd_we    (out_rd_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rdwe;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t        expq [$];
  logic [31:0] m_regs [NREG];
  bit          m_out_valid;
  exp_t        m_out;
`ifdef DECODE_SCOREBOARD_EN
  bit          m_busy [NREG];
`endif

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Immediate value by format, computed arithmetically from the field weights.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = int'(w[30:20]) - (int'(w[31]) << 11);
      7'h23: v = (int'(w[30:25]) << 5) + int'(w[11:7]) - (int'(w[31]) << 11);
      7'h63: v = (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1)
                 - (int'(w[31]) << 12);
      7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
      7'h6F: v = (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1)
                 - (int'(w[31]) << 20);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Architectural read: x0 is zero, otherwise the newest value including this cycle's writebacks.
  function automatic logic [31:0] ref_read(input logic [4:0] s, input logic [1:0] we,
                                           input logic [9:0] wa, input logic [63:0] wd);
    logic [31:0] v;
    if (s == 0) return 32'h0;
    v = m_regs[s];
    for (int i = 0; i < NWB; i++) begin
      if (we[i] && wa[i*5 +: 5] == s) v = wd[i*32 +: 32];
    end
    return v;
  endfunction

`ifdef DECODE_SCOREBOARD_EN
  function automatic bit ref_pending(input logic [4:0] s, input logic [1:0] we, input logic [9:0] wa);
    bit wb_now = 0;
    if (s == 0) return 0;
    for (int i = 0; i < NWB; i++) if (we[i] && wa[i*5 +: 5] == s) wb_now = 1;
    return (m_busy[s] && !wb_now) || (m_out_valid && m_out.rdwe && m_out.rd == s);
  endfunction
`endif

  // One clock of stimulus; entered and left at posedge+1.
  task automatic drive_cycle(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                             input bit fl, input bit ordy, input logic [1:0] we,
                             input logic [9:0] wa, input logic [63:0] wd, output bit acc);
    exp_t e;
    bit haz, rdy, issue;
    logic [6:0] op;
    in_valid = v; in_pc = pc; in_instr = instr; flush = fl; out_ready = ordy;
    wb_we = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    op  = instr[6:0];
    haz = 0;
`ifdef DECODE_SCOREBOARD_EN
    if (!(op == 7'h37 || op == 7'h17 || op == 7'h6F) && ref_pending(instr[19:15], we, wa)) haz = 1;
    if ((op == 7'h33 || op == 7'h23 || op == 7'h63) && ref_pending(instr[24:20], we, wa)) haz = 1;
`endif
    rdy = (!m_out_valid || ordy) && !haz && !fl;
    chk("out_valid", out_valid, m_out_valid);
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (acc) begin
      e.pc    = pc;
      e.instr = instr;
      e.rs1   = instr[19:15];
      e.rs2   = instr[24:20];
      e.rd    = instr[11:7];
      e.d1    = ref_read(instr[19:15], we, wa, wd);
      e.d2    = ref_read(instr[24:20], we, wa, wd);
      e.imm   = ref_imm(instr);
      e.rdwe  = (op != 7'h23) && (op != 7'h63) && (instr[11:7] != 0);
      expq.push_back(e);
    end
    issue = m_out_valid && ordy && !fl;
`ifdef DECODE_SCOREBOARD_EN
    for (int i = 0; i < NWB; i++) if (we[i]) m_busy[wa[i*5 +: 5]] = 0;
    if (issue && m_out.rdwe) m_busy[m_out.rd] = 1;
    m_busy[0] = 0;
`endif
    for (int i = 0; i < NWB; i++) begin
      if (we[i] && wa[i*5 +: 5] != 0) m_regs[wa[i*5 +: 5]] = wd[i*32 +: 32];
    end
    if (fl) m_out_valid = 0;
    else if (acc) begin m_out = e; m_out_valid = 1; end
    else if (ordy || issue) m_out_valid = 0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented bundle with the queue head; retire on consume or flush.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_queue: got out_valid=1 pc %h want no bundle", out_pc);
      end else begin
        mon_e = expq[0];
        chk("mon_pc", out_pc, mon_e.pc);
        chk("mon_instr", out_instr, mon_e.instr);
        chk("mon_rs1", out_rs1, mon_e.rs1);
        chk("mon_rs2", out_rs2, mon_e.rs2);
        chk("mon_rd", out_rd, mon_e.rd);
        chk("mon_rs1_data", out_rs1_data, mon_e.d1);
        chk("mon_rs2_data", out_rs2_data, mon_e.d2);
        chk("mon_imm", out_imm, mon_e.imm);
        chk("mon_rd_we", out_rd_we, mon_e.rdwe);
        if (out_ready || flush) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] instr;
    logic [6:0]  ops [11];
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h13, 7'h33, 7'h73, 7'h0B};

    rst = 1; in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; out_ready = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = 0;
`ifdef DECODE_SCOREBOARD_EN
      m_busy[r] = 0;
`endif
    end
    m_out_valid = 0;
    m_out = '0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_data", {out_rs1_data, out_rs2_data}, 0);
    chk("rst_out_imm_rdwe", {out_imm, out_rd_we}, 0);

    // addi x1,x5,0 : x5 reads zero after reset
    drive_cycle(1, 32'h100, 32'h0002_8093, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("reset_read_x5", {out_valid, out_rs1_data}, {1'b1, 32'h0});

    // addi x4,x3,-1 accepted while port0 writes x3
    drive_cycle(1, 32'h104, 32'hFFF1_8213, 0, 1, 2'b01, {5'd0, 5'd3},
                {32'h0, 32'hDEAD_BEEF}, acc);
    chk("bypass_rs1", out_rs1_data, 32'hDEAD_BEEF);
    chk("bypass_imm", out_imm, 32'hFFFF_FFFF);

    // both ports write x7, then addi x8,x7,0 reads it
    drive_cycle(0, 32'h0, 32'h0, 0, 1, 2'b11, {5'd7, 5'd7}, {32'h2, 32'h1}, acc);
    drive_cycle(1, 32'h108, 32'h0003_8413, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("multiport_x7", out_rs1_data, 32'h2);

    // lw x5,0(x0) then add x6,x5,x5 interlocked until x5 is written back
    drive_cycle(1, 32'h10C, 32'h0000_2283, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    repeat (3) drive_cycle(1, 32'h110, 32'h0052_8333, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    drive_cycle(1, 32'h110, 32'h0052_8333, 0, 1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h55}, acc);
    chk("raw_rs_data", {out_pc, out_rs1_data, out_rs2_data}, {32'h110, 32'h55, 32'h55});

    // backpressure hold, then flush kills addi x9 without marking x9 busy
    drive_cycle(1, 32'h200, 32'h0050_0493, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    repeat (2) drive_cycle(1, 32'h204, 32'h0004_8513, 0, 0, 2'b00, 10'h0, 64'h0, acc);
    chk("bp_hold", {out_valid, out_pc, out_imm}, {1'b1, 32'h200, 32'h5});
    chk("bp_in_ready", in_ready, 0);
    drive_cycle(1, 32'h204, 32'h0004_8513, 1, 0, 2'b00, 10'h0, 64'h0, acc);
    chk("flush_valid", out_valid, 0);
    drive_cycle(1, 32'h204, 32'h0004_8513, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("post_flush_accept", {out_valid, out_pc}, {1'b1, 32'h204});

    // immediate formats and store rd_we
    drive_cycle(1, 32'h300, 32'hFE00_0EE3, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("imm_b", out_imm, 32'hFFFF_FFFC);
    drive_cycle(1, 32'h304, 32'h1234_5037, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("imm_u", out_imm, 32'h1234_5000);
    drive_cycle(1, 32'h308, 32'h0000_006F, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("imm_j", {out_pc, out_imm}, {32'h308, 32'h0});
    drive_cycle(1, 32'h30C, 32'h0000_2023, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("sw_rd_we", {out_pc, out_rd_we}, {32'h30C, 1'b0});

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      instr = $urandom;
      instr[6:0]   = ops[$urandom_range(0, 10)];
      instr[11:7]  = 5'($urandom_range(0, 7));
      instr[19:15] = 5'($urandom_range(0, 7));
      instr[24:20] = 5'($urandom_range(0, 7));
      drive_cycle($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, instr,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  2'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                  {32'($urandom), 32'($urandom)}, acc);
    end

    repeat (4) drive_cycle(0, 32'h0, 32'h0, 0, 1, 2'b00, 10'h0, 64'h0, acc);
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
